// File: rtl/mfp_uart_tx.sv
// mfp_uart_tx - 8N1 UART transmitter with a write FIFO for the MIPSfpga
// Nexys4 DDR system.
//
// Bus writes push bytes into a small circular FIFO. A four-state machine
// pops bytes and serializes them as: start bit, 8 data bits LSB-first,
// stop bit. Each bit lasts BAUD_DIV clocks. Back-to-back frames have no
// idle gap between them.
//
// Parameters
//   BAUD_DIV    clocks per bit, 2..65535 (434 = 115200 baud at 50 MHz)
//   FIFO_DEPTH  FIFO entries; must be a power of two and at least 2
//
// Ports
//   SI_ClkIn       system clock (rising edge)
//   SI_Reset_N     synchronous active-low reset
//   tx_wr_en       single-cycle write strobe
//   tx_data        byte to enqueue
//   tx_fifo_full   FIFO holds FIFO_DEPTH entries
//   tx_fifo_empty  FIFO holds no entries
//   tx_fifo_count  current FIFO occupancy
//   tx_busy        a frame is in progress
//   tx_overflow    sticky; set by a write while full, cleared by reset
//   UART_TX        registered serial line, idle high
module mfp_uart_tx #(
    parameter int BAUD_DIV   = 434,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                              SI_ClkIn,
    input  logic                              SI_Reset_N,
    input  logic                              tx_wr_en,
    input  logic [7:0]                        tx_data,
    output logic                              tx_fifo_full,
    output logic                              tx_fifo_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   tx_fifo_count,
    output logic                              tx_busy,
    output logic                              tx_overflow,
    output logic                              UART_TX
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;

    // Serializer state
    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nxt;
    logic [2:0]    r_bitcnt;
    logic [2:0]    w_bitcnt_nxt;
    logic [BW-1:0] r_baud;
    logic [BW-1:0] w_baud_nxt;
    logic          r_tx;
    logic          w_tx_nxt;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_baud_end;

    // Flags come from the registered count only, so "full" is the value
    // before the edge. A write therefore cannot slip in on the same edge
    // that a pop takes the FIFO out of full.
    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_push     = tx_wr_en && !w_full;
    assign w_baud_end = (r_baud == BW'(BAUD_DIV - 1));

    // Storage has no reset. Stale entries are unreachable once the
    // pointers are cleared.
    always_ff @(posedge SI_ClkIn) begin
        if (w_push) begin
            r_mem[r_wptr] <= tx_data;
        end
    end

    always_ff @(posedge SI_ClkIn) begin
        if (!SI_Reset_N) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            // A simultaneous push and pop leaves the count unchanged.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (tx_wr_en && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge SI_ClkIn) begin
        if (!SI_Reset_N) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_baud   <= '0;
            r_tx     <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_baud   <= w_baud_nxt;
            r_tx     <= w_tx_nxt;
        end
    end

    // The line value is computed one cycle ahead so that UART_TX comes
    // straight from a flop. Every state change happens on a baud wrap,
    // so the baud counter is always 0 on entry to a new state.
    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_bitcnt_nxt = r_bitcnt;
        w_baud_nxt   = w_baud_end ? '0 : r_baud + BW'(1);
        w_tx_nxt     = r_tx;
        w_pop        = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                w_tx_nxt   = 1'b1;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_nxt  = r_mem[r_rptr];
                    w_bitcnt_nxt = '0;
                    w_state_nxt  = S_START;
                    w_tx_nxt     = 1'b0;
                end
            end
            S_START: begin
                w_tx_nxt = 1'b0;
                if (w_baud_end) begin
                    w_state_nxt = S_DATA;
                    w_tx_nxt    = r_shift[0];
                end
            end
            S_DATA: begin
                w_tx_nxt = r_shift[0];
                if (w_baud_end) begin
                    w_shift_nxt  = {1'b0, r_shift[7:1]};
                    w_bitcnt_nxt = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_tx_nxt = r_shift[1];
                    end
                end
            end
            S_STOP: begin
                w_tx_nxt = 1'b1;
                if (w_baud_end) begin
                    // Chain straight into the next start bit when more
                    // data is waiting, so no idle cycle is inserted.
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shift_nxt  = r_mem[r_rptr];
                        w_bitcnt_nxt = '0;
                        w_state_nxt  = S_START;
                        w_tx_nxt     = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    assign tx_fifo_full  = w_full;
    assign tx_fifo_empty = w_empty;
    assign tx_fifo_count = r_count;
    assign tx_busy       = (r_state != S_IDLE);
    assign tx_overflow   = r_ovf;
    assign UART_TX       = r_tx;

endmodule

// File: tb/tb_mfp_uart_tx.sv
// tb_mfp_uart_tx - directed bench for mfp_uart_tx with BAUD_DIV=4 and
// FIFO_DEPTH=4.
//
// A monitor records UART_TX and tx_busy into bit vectors one time step
// after each rising edge. Each captured waveform is then compared with a
// waveform built from hand-derived 8N1 frames.
module tb_mfp_uart_tx;

    localparam int BD = 4;
    localparam int FD = 4;
    localparam int CW = $clog2(FD + 1);

    logic          SI_ClkIn;
    logic          SI_Reset_N;
    logic          tx_wr_en;
    logic [7:0]    tx_data;
    logic          tx_fifo_full;
    logic          tx_fifo_empty;
    logic [CW-1:0] tx_fifo_count;
    logic          tx_busy;
    logic          tx_overflow;
    logic          UART_TX;

    int            n_cmp = 0;
    int            n_err = 0;

    logic          cap_en = 1'b0;
    int            cap_n;
    logic [255:0]  cap_tx;
    logic [255:0]  cap_busy;

    mfp_uart_tx #(
        .BAUD_DIV   (BD),
        .FIFO_DEPTH (FD)
    ) dut (
        .SI_ClkIn      (SI_ClkIn),
        .SI_Reset_N    (SI_Reset_N),
        .tx_wr_en      (tx_wr_en),
        .tx_data       (tx_data),
        .tx_fifo_full  (tx_fifo_full),
        .tx_fifo_empty (tx_fifo_empty),
        .tx_fifo_count (tx_fifo_count),
        .tx_busy       (tx_busy),
        .tx_overflow   (tx_overflow),
        .UART_TX       (UART_TX)
    );

    initial begin
        SI_ClkIn = 1'b0;
        forever #5 SI_ClkIn = ~SI_ClkIn;
    end

    // Sample shortly after each rising edge. The buffers are cleared
    // whenever capture is off.
    always @(posedge SI_ClkIn) begin
        #1;
        if (!cap_en) begin
            cap_n    = 0;
            cap_tx   = '0;
            cap_busy = '0;
        end else if (cap_n < 256) begin
            cap_tx[cap_n]   = UART_TX;
            cap_busy[cap_n] = tx_busy;
            cap_n++;
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line waveform of one 8N1 frame (BD cycles per bit), placed at
    // cycle offset off.
    function automatic logic [255:0] fr(input logic [7:0] b, input int off);
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < 10 * BD; i++) begin
            int k;
            k = i / BD;
            if (k == 0)      v[off+i] = 1'b0;
            else if (k == 9) v[off+i] = 1'b1;
            else             v[off+i] = b[k-1];
        end
        return v;
    endfunction

    function automatic logic [255:0] rng(input int lo, input int hi);
        logic [255:0] v;
        v = '0;
        for (int i = lo; i <= hi; i++) v[i] = 1'b1;
        return v;
    endfunction

    // Drive a write for one edge. Entered and left at a falling edge.
    task automatic wr(input logic [7:0] d);
        tx_wr_en = 1'b1;
        tx_data  = d;
        @(negedge SI_ClkIn);
        tx_wr_en = 1'b0;
    endtask

    initial begin
        logic [7:0] dv [4];
        dv = '{8'h22, 8'h33, 8'h44, 8'h55};
        SI_Reset_N = 1'b0;
        tx_wr_en   = 1'b0;
        tx_data    = 8'h00;

        // Reset values and quiet idle line.
        repeat (3) @(negedge SI_ClkIn);
        SI_Reset_N = 1'b1;
        chk("rst_tx",    UART_TX, 1);
        chk("rst_busy",  tx_busy, 0);
        chk("rst_empty", tx_fifo_empty, 1);
        chk("rst_full",  tx_fifo_full, 0);
        chk("rst_count", tx_fifo_count, 0);
        chk("rst_ovf",   tx_overflow, 0);
        cap_en = 1'b1;
        repeat (8) @(negedge SI_ClkIn);
        cap_en = 1'b0;
        chk("idle_tx",   cap_tx, rng(0, 7));
        chk("idle_busy", cap_busy, 0);

        // Single byte 0xA5.
        wr(8'hA5);
        chk("wr_empty", tx_fifo_empty, 0);
        chk("wr_count", tx_fifo_count, 1);
        chk("wr_tx",    UART_TX, 1);
        cap_en = 1'b1;
        repeat (41) @(negedge SI_ClkIn);
        cap_en = 1'b0;
        chk("a5_line", cap_tx, fr(8'hA5, 0) | rng(40, 40));
        chk("a5_busy", cap_busy, rng(0, 39));

        // Back-to-back 0x00 then 0xFF. The second write lands on the pop edge.
        tx_wr_en = 1'b1;
        tx_data  = 8'h00;
        @(negedge SI_ClkIn);
        tx_data = 8'hFF;
        cap_en  = 1'b1;
        @(negedge SI_ClkIn);
        tx_wr_en = 1'b0;
        chk("b2b_count", tx_fifo_count, 1);
        repeat (80) @(negedge SI_ClkIn);
        cap_en = 1'b0;
        chk("b2b_line", cap_tx, fr(8'h00, 0) | fr(8'hFF, 40) | rng(80, 80));
        chk("b2b_busy", cap_busy, rng(0, 79));

        // Overflow: 0x66 is dropped while the FIFO is full.
        wr(8'h11);
        cap_en = 1'b1;
        @(negedge SI_ClkIn);
        for (int i = 0; i < 4; i++) begin
            tx_wr_en = 1'b1;
            tx_data  = dv[i];
            @(negedge SI_ClkIn);
        end
        chk("ovf_full_4", tx_fifo_full, 1);
        chk("ovf_cnt_4",  tx_fifo_count, 4);
        chk("ovf_pre",    tx_overflow, 0);
        tx_data = 8'h66;
        @(negedge SI_ClkIn);
        tx_wr_en = 1'b0;
        chk("ovf_set",   tx_overflow, 1);
        chk("ovf_cnt_5", tx_fifo_count, 4);
        repeat (204) @(negedge SI_ClkIn);
        cap_en = 1'b0;
        chk("ovf_line", cap_tx, fr(8'h11, 0) | fr(8'h22, 40) | fr(8'h33, 80)
                                | fr(8'h44, 120) | fr(8'h55, 160) | rng(200, 209));
        chk("ovf_busy",   cap_busy, rng(0, 199));
        chk("ovf_sticky", tx_overflow, 1);
        chk("ovf_empty",  tx_fifo_empty, 1);

        // Simultaneous write and pop at a STOP-to-START edge.
        SI_Reset_N = 1'b0;
        @(negedge SI_ClkIn);
        SI_Reset_N = 1'b1;
        chk("ovf_clr", tx_overflow, 0);
        wr(8'hA1);
        cap_en = 1'b1;
        @(negedge SI_ClkIn);
        wr(8'hB2);
        wr(8'hC3);
        chk("sim_cnt_pre", tx_fifo_count, 2);
        repeat (37) @(negedge SI_ClkIn);
        chk("sim_stop_tx", UART_TX, 1);
        chk("sim_cnt_stop", tx_fifo_count, 2);
        wr(8'hD4);
        chk("sim_cnt_post", tx_fifo_count, 2);
        chk("sim_busy",     tx_busy, 1);
        chk("sim_start_tx", UART_TX, 0);
        repeat (129) @(negedge SI_ClkIn);
        cap_en = 1'b0;
        chk("sim_line", cap_tx, fr(8'hA1, 0) | fr(8'hB2, 40) | fr(8'hC3, 80)
                                | fr(8'hD4, 120) | rng(160, 169));
        chk("sim_busy_w", cap_busy, rng(0, 159));

        // Reset in the 15th cycle of a 0x3C frame with two bytes queued.
        wr(8'h3C);
        @(negedge SI_ClkIn);
        wr(8'h5A);
        wr(8'h69);
        repeat (12) @(negedge SI_ClkIn);
        chk("mid_cnt_pre",  tx_fifo_count, 2);
        chk("mid_busy_pre", tx_busy, 1);
        SI_Reset_N = 1'b0;
        @(negedge SI_ClkIn);
        SI_Reset_N = 1'b1;
        chk("mid_tx",    UART_TX, 1);
        chk("mid_count", tx_fifo_count, 0);
        chk("mid_busy",  tx_busy, 0);
        chk("mid_empty", tx_fifo_empty, 1);
        cap_en = 1'b1;
        repeat (60) @(negedge SI_ClkIn);
        cap_en = 1'b0;
        chk("mid_line", cap_tx, rng(0, 59));
        chk("mid_idle", cap_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mfp_uart_tx.md
# mfp_uart_tx

UART transmitter for the MIPSfpga Nexys4 DDR system, the transmit counterpart to the existing `UART_RX` receive path. Bytes are written by a memory-mapped I/O register on the system bus into a small FIFO. Each byte is serialized as an 8N1 frame (start bit, 8 data bits LSB-first, one stop bit) on `UART_TX`, which the top level routes to the board's USB-UART bridge pin.

## Interface
- `BAUD_DIV`, default 434: clock cycles per bit. 434 gives 115200 baud at the 50 MHz `SI_ClkIn`. Legal range is 2..65535.
- `FIFO_DEPTH`, default 16: FIFO entries. Must be a power of two, at least 2.
- `SI_ClkIn`  in  1: system clock. All logic is clocked on its rising edge.
- `SI_Reset_N`  in  1: synchronous, active-low reset.
- `tx_wr_en`  in  1: single-cycle write strobe from the bus register.
- `tx_data`  in  8: byte to enqueue, sampled when `tx_wr_en` is high.
- `tx_fifo_full`  out  1: FIFO holds `FIFO_DEPTH` entries.
- `tx_fifo_empty`  out  1: FIFO holds 0 entries.
- `tx_fifo_count`  out  $clog2(FIFO_DEPTH+1): current number of FIFO entries.
- `tx_busy`  out  1: a frame is in progress (state is not IDLE).
- `tx_overflow`  out  1: sticky flag, set when a write arrives while the FIFO is full.
- `UART_TX`  out  1: serial line, idle high. Registered output.

## Operation
- **FIFO:** circular buffer with read and write pointers plus an occupancy count. All flags are derived from the registered count.
- **Write handling:**
  - A write is accepted on an edge where `tx_wr_en`=1 and `tx_fifo_full`=0.
  - A write while full is dropped, sets `tx_overflow`, and leaves FIFO contents untouched.
  - `tx_overflow` clears only on reset.
- **Simultaneous write and pop (not full):** both take effect and the count is unchanged. A write cannot be accepted on the same edge the FIFO transitions out of full; full is evaluated before the edge.
- **State machine states:** IDLE, START, DATA, STOP.
- **State transitions:**
  - IDLE: if the FIFO is not empty, pop the head into the shift register, clear the bit counter and baud counter, and go to START.
  - START: `UART_TX`=0 for `BAUD_DIV` cycles, then go to DATA.
  - DATA: `UART_TX`=shift[0]. Every `BAUD_DIV` cycles, shift right and increment the bit index. After the 8th bit period, go to STOP.
  - STOP: `UART_TX`=1 for `BAUD_DIV` cycles.
    - On the final STOP cycle with the FIFO not empty: pop and go directly to START, with no idle gap.
    - Otherwise go to IDLE.
- **Baud counter:** counts 0..`BAUD_DIV`-1, wraps to 0, and resets to 0 on every state entry.
- **Bit counter:** 3 bits, wraps from 7.
- **Outputs:**
  - `UART_TX` is driven from a register. It is 1 in IDLE and STOP.
  - `tx_busy` is 1 in START, DATA and STOP.
- **Reset values** (`SI_Reset_N`=0 on an edge):
  - `UART_TX`=1, `tx_busy`=0.
  - `tx_fifo_empty`=1, `tx_fifo_full`=0, `tx_fifo_count`=0.
  - `tx_overflow`=0.
  - State is IDLE and all pointers and counters are 0.
- **Reset mid-frame:** the frame is aborted and the line returns high on that edge. Queued bytes are discarded; no partial-frame completion.

## Timing
- **Write latency:** a write accepted at edge N makes `tx_fifo_empty`=0 and the count increment after edge N.
- **Frame start:** if IDLE, the pop happens at edge N+1, and `UART_TX` falls and `tx_busy` rises after edge N+1.
- **Bit duration:** exactly `BAUD_DIV` cycles for each of the 10 bits, so a frame is 10×`BAUD_DIV` cycles.
- **Back-to-back frames:** the next start bit begins the cycle immediately after the last stop-bit cycle. Sustained throughput is one byte per 10×`BAUD_DIV` cycles.
- **End of traffic:** `tx_busy` falls after the final STOP cycle when the FIFO is empty.
- **Pop timing:** the FIFO pop is visible in `tx_fifo_count` the cycle after the pop edge.
- **Frame isolation:** a write never alters a frame already in progress.

## Test plan
Bench parameters: `BAUD_DIV`=4, `FIFO_DEPTH`=4.
- **Reset values:** hold `SI_Reset_N`=0 for 3 cycles, then release. Required: `UART_TX`=1, `tx_busy`=0, `tx_fifo_empty`=1, `tx_fifo_count`=0, `tx_overflow`=0 with no activity.
- **Single byte:** write 0xA5 while IDLE. Required:
  - `UART_TX` carries the sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles, starting one cycle after the write edge.
  - `tx_busy` stays high for exactly 40 cycles.
- **Back-to-back bytes:** write 0x00 then 0xFF on consecutive cycles. Required:
  - 80 contiguous cycles of framing: start, 8 zeros, stop, then start, 8 ones, stop.
  - No idle cycle between the frames.
- **Overflow:** during the first frame of 0x11, write 0x22, 0x33, 0x44, 0x55, 0x66 on consecutive cycles. Required:
  - `tx_fifo_full`=1 after the 4th write.
  - 0x66 is dropped and `tx_overflow`=1.
  - Serial output is 0x11, 0x22, 0x33, 0x44, 0x55, then idle.
- **Reset mid-frame:** while 0x3C is in its 15th frame cycle with 2 bytes queued, pulse reset for 1 cycle. Required:
  - `UART_TX`=1 and `tx_fifo_count`=0 after that edge.
  - No further frames are transmitted.
- **Simultaneous write and pop:** the FIFO holds 2 entries and a write lands on the STOP→START pop edge. Required: `tx_fifo_count` stays at 2 and byte order is preserved.
